// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: tracks in-flight register writes from issue
// until retirement, and answers decode-stage "is this source still pending
// (and is it a load)" queries to drive the decode stall.
module reg_write_scoreboard #(
  parameter int CNT_W  = 2,
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic       issue_wen,
  input  logic [4:0] issue_rd,
  input  logic       issue_load,
  input  logic       wb_valid,
  input  logic       wb_wen,
  input  logic [4:0] wb_rd,
  input  logic       flush,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic       use_rs2,
  output logic       busy_rs1,
  output logic       busy_rs2,
  output logic       stall_D,
  output logic [5:0] pend_total,
  output logic       wb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [5:0]       TOT_MAX = 6'd63;

  // Entry 0 exists only to keep indexing uniform; rd==0 never updates it.
  logic [CNT_W-1:0] cnt_reg  [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic [31:0]      ld_reg;
  logic [31:0]      ld_next;
  logic [5:0]       pend_total_reg;
  logic [5:0]       pend_total_next;
  logic             wb_underflow_reg;
  logic             wb_underflow_next;

  logic issue_fire;
  logic issue_upd;
  logic wb_upd;
  logic wb_dec;
  logic wb_under;

  // Issue is refused on flush or when the destination counter is full; a
  // concurrent retirement to the same register does not free the slot early.
  assign issue_ready = !flush && (cnt_reg[issue_rd] != CNT_MAX);
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_upd   = issue_fire && issue_wen && (issue_rd != 5'd0);
  assign wb_upd      = wb_valid && wb_wen && (wb_rd != 5'd0) && !flush;
  assign wb_dec      = wb_upd && (cnt_reg[wb_rd] != '0);
  assign wb_under    = wb_upd && (cnt_reg[wb_rd] == '0);

  // Per-register next state: increment on issue, decrement on retirement,
  // youngest issued writer decides whether the pending value is a load.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      logic inc_hit;
      logic dec_hit;
      assign inc_hit = issue_upd && (issue_rd == gi[4:0]);
      assign dec_hit = wb_dec && (wb_rd == gi[4:0]);

      // Counter and load-flag update for one architectural register.
      always_comb begin
        cnt_next[gi] = cnt_reg[gi];
        ld_next[gi]  = ld_reg[gi];
        if (flush) begin
          cnt_next[gi] = '0;
          ld_next[gi]  = 1'b0;
        end else if (inc_hit && !dec_hit) begin
          cnt_next[gi] = cnt_reg[gi] + 1'b1;
          ld_next[gi]  = issue_load;
        end else if (dec_hit && !inc_hit) begin
          cnt_next[gi] = cnt_reg[gi] - 1'b1;
          if (cnt_reg[gi] == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            ld_next[gi] = 1'b0;
          end
        end else if (inc_hit && dec_hit) begin
          ld_next[gi] = issue_load;
        end
      end
    end
  endgenerate

  // Aggregate pending count (saturating) and sticky underflow flag.
  always_comb begin
    pend_total_next   = pend_total_reg;
    wb_underflow_next = wb_underflow_reg | wb_under;
    if (flush) begin
      pend_total_next = 6'd0;
    end else if (issue_upd && !wb_dec) begin
      if (pend_total_reg != TOT_MAX) pend_total_next = pend_total_reg + 6'd1;
    end else if (wb_dec && !issue_upd) begin
      if (pend_total_reg != 6'd0) pend_total_next = pend_total_reg - 6'd1;
    end
  end

  // State registers; reset overrides flush, issue and retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt_reg[i] <= '0;
      ld_reg           <= '0;
      pend_total_reg   <= 6'd0;
      wb_underflow_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_next;
      ld_reg           <= ld_next;
      pend_total_reg   <= pend_total_next;
      wb_underflow_reg <= wb_underflow_next;
    end
  end

  // Decode queries read current state only; same-cycle updates are not bypassed.
  assign busy_rs1     = (rs1_D != 5'd0) && (cnt_reg[rs1_D] != '0);
  assign busy_rs2     = use_rs2 && (rs2_D != 5'd0) && (cnt_reg[rs2_D] != '0);
  assign pend_total   = pend_total_reg;
  assign wb_underflow = wb_underflow_reg;

  generate
    if (FWD_EN) begin : g_fwd
      // Forwarding covers ALU results; only a pending load must hold decode.
      assign stall_D = (busy_rs1 && ld_reg[rs1_D]) || (busy_rs2 && ld_reg[rs2_D]);
    end else begin : g_nofwd
      assign stall_D = busy_rs1 || busy_rs2;
    end
  endgenerate

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard: one instance with forwarding
// enabled and a second with forwarding disabled sharing the same stimulus.
module tb_reg_write_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_wen;
  logic [4:0] issue_rd;
  logic       issue_load;
  logic       wb_valid;
  logic       wb_wen;
  logic [4:0] wb_rd;
  logic       flush;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic       use_rs2;

  logic       issue_ready, busy_rs1, busy_rs2, stall_D, wb_underflow;
  logic [5:0] pend_total;
  logic       issue_ready_nf, busy_rs1_nf, busy_rs2_nf, stall_D_nf, wb_underflow_nf;
  logic [5:0] pend_total_nf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_write_scoreboard #(.CNT_W(2), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_load(issue_load),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .flush(flush),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs2(use_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .stall_D(stall_D),
    .pend_total(pend_total), .wb_underflow(wb_underflow)
  );

  reg_write_scoreboard #(.CNT_W(2), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready_nf), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_load(issue_load),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .flush(flush),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs2(use_rs2),
    .busy_rs1(busy_rs1_nf), .busy_rs2(busy_rs2_nf), .stall_D(stall_D_nf),
    .pend_total(pend_total_nf), .wb_underflow(wb_underflow_nf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = 5'd0; issue_load = 1'b0;
    wb_valid = 1'b0; wb_wen = 1'b0; wb_rd = 5'd0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic load);
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd; issue_load = load;
    tick();
  endtask

  task automatic do_wb(input logic [4:0] rd);
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = rd;
    tick();
  endtask

  task automatic query(input logic [4:0] r1, input logic [4:0] r2, input logic u2);
    rs1_D = r1; rs2_D = r2; use_rs2 = u2;
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    query(5'd5, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", issue_ready, 1);
    check("rst_busy1", busy_rs1, 0);
    check("rst_stall", stall_D, 0);
    check("rst_pend", pend_total, 0);
    check("rst_under", wb_underflow, 0);

    // 1: ALU write to x5
    do_issue(5'd5, 1'b0);
    query(5'd5, 5'd0, 1'b0);
    check("t1_busy1", busy_rs1, 1);
    check("t1_stall_fwd", stall_D, 0);
    check("t1_stall_nofwd", stall_D_nf, 1);
    check("t1_pend", pend_total, 1);
    do_wb(5'd5);
    check("t1_busy1_after_wb", busy_rs1, 0);
    check("t1_pend_after_wb", pend_total, 0);

    // 2: load write to x7 queried via rs2
    do_issue(5'd7, 1'b1);
    query(5'd0, 5'd7, 1'b1);
    check("t2_busy2", busy_rs2, 1);
    check("t2_stall", stall_D, 1);
    query(5'd0, 5'd7, 1'b0);
    check("t2_busy2_nouse", busy_rs2, 0);
    check("t2_stall_nouse", stall_D, 0);
    do_wb(5'd7);
    query(5'd0, 5'd7, 1'b1);
    check("t2_busy2_after_wb", busy_rs2, 0);
    check("t2_stall_after_wb", stall_D, 0);

    // 3: fill x3 counter to max
    do_issue(5'd3, 1'b0);
    do_issue(5'd3, 1'b0);
    do_issue(5'd3, 1'b0);
    issue_rd = 5'd3;
    #1;
    check("t3_ready_full", issue_ready, 0);
    check("t3_pend", pend_total, 3);
    issue_valid = 1'b1; issue_wen = 1'b1;
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd3;
    #1;
    check("t3_ready_full_wb", issue_ready, 0);
    tick();
    issue_rd = 5'd3;
    #1;
    check("t3_pend_after", pend_total, 2);
    check("t3_ready_after", issue_ready, 1);
    do_wb(5'd3);
    do_wb(5'd3);
    query(5'd3, 5'd0, 1'b0);
    check("t3_busy_drained", busy_rs1, 0);

    // 4: youngest writer decides the load flag
    do_issue(5'd9, 1'b1);
    do_issue(5'd9, 1'b0);
    query(5'd9, 5'd0, 1'b0);
    check("t4_busy1", busy_rs1, 1);
    check("t4_stall_alu_young", stall_D, 0);
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd9; issue_load = 1'b1;
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd9;
    tick();
    check("t4_pend_same_cycle", pend_total, 2);
    check("t4_stall_load_young", stall_D, 1);
    do_wb(5'd9);
    do_wb(5'd9);
    check("t4_busy_drained", busy_rs1, 0);
    check("t4_pend_drained", pend_total, 0);

    // 5: flush squashes everything and blocks issue
    do_issue(5'd1, 1'b1);
    do_issue(5'd2, 1'b0);
    do_issue(5'd4, 1'b1);
    check("t5_pend", pend_total, 3);
    flush = 1'b1;
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd6;
    #1;
    check("t5_ready_flush", issue_ready, 0);
    tick();
    check("t5_pend_flushed", pend_total, 0);
    query(5'd1, 5'd2, 1'b1);
    check("t5_busy1_x1", busy_rs1, 0);
    check("t5_busy2_x2", busy_rs2, 0);
    query(5'd4, 5'd6, 1'b1);
    check("t5_busy1_x4", busy_rs1, 0);
    check("t5_busy2_x6", busy_rs2, 0);

    // 6: underflow is sticky across flush, cleared only by reset
    do_wb(5'd12);
    check("t6_under", wb_underflow, 1);
    check("t6_pend", pend_total, 0);
    flush = 1'b1;
    tick();
    check("t6_under_flush", wb_underflow, 1);
    do_issue(5'd0, 1'b1);
    check("t6_pend_rd0_issue", pend_total, 0);
    query(5'd0, 5'd0, 1'b1);
    check("t6_busy_rd0", busy_rs1, 0);
    do_wb(5'd0);
    check("t6_pend_rd0_wb", pend_total, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_under_rst", wb_underflow, 0);

    // pend_total saturation: 31 registers x 3 writes = 93 > 63
    for (int r = 1; r < 32; r++) begin
      for (int k = 0; k < 3; k++) do_issue(r[4:0], 1'b0);
    end
    check("sat_pend", pend_total, 63);
    flush = 1'b1;
    tick();
    check("sat_pend_flushed", pend_total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
